// File: rtl/vec_pipe_hazard_ctrl_if.sv
// vec_pipe_hazard_ctrl_if
//   Bus between the vector datapath and its hazard controller.
//   master : datapath side; drives Decode-stage fields and mem_ready, sees control outputs.
//   slave  : controller side; the reverse.
//   Decode : valid_d, ra1_d, ra2_d, use1_d, use2_d, wa_d, regwrite_d, memtoreg_d, memwrite_d
//   Memory : mem_ready (in), mem_req_m, mem_we_m (out)
//   Control: stall_fd, flush_e, hold_em, fwd_a_e, fwd_b_e, wbyp1_d, wbyp2_d
//   W stage: regwrite_w, wa_w
//   Perf   : stall_cnt, retire_cnt
interface vec_pipe_hazard_ctrl_if #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
);
  logic            valid_d;
  logic [RA_W-1:0] ra1_d;
  logic [RA_W-1:0] ra2_d;
  logic            use1_d;
  logic            use2_d;
  logic [RA_W-1:0] wa_d;
  logic            regwrite_d;
  logic            memtoreg_d;
  logic            memwrite_d;
  logic            mem_ready;

  logic             stall_fd;
  logic             flush_e;
  logic             hold_em;
  logic [1:0]       fwd_a_e;
  logic [1:0]       fwd_b_e;
  logic             wbyp1_d;
  logic             wbyp2_d;
  logic             mem_req_m;
  logic             mem_we_m;
  logic             regwrite_w;
  logic [RA_W-1:0]  wa_w;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] retire_cnt;

  modport master (
    output valid_d, ra1_d, ra2_d, use1_d, use2_d, wa_d, regwrite_d, memtoreg_d, memwrite_d,
           mem_ready,
    input  stall_fd, flush_e, hold_em, fwd_a_e, fwd_b_e, wbyp1_d, wbyp2_d, mem_req_m, mem_we_m,
           regwrite_w, wa_w, stall_cnt, retire_cnt
  );

  modport slave (
    input  valid_d, ra1_d, ra2_d, use1_d, use2_d, wa_d, regwrite_d, memtoreg_d, memwrite_d,
           mem_ready,
    output stall_fd, flush_e, hold_em, fwd_a_e, fwd_b_e, wbyp1_d, wbyp2_d, mem_req_m, mem_we_m,
           regwrite_w, wa_w, stall_cnt, retire_cnt
  );
endinterface

// File: rtl/vec_pipe_hazard_ctrl.sv
// vec_pipe_hazard_ctrl
//   Pipeline control for the 5-stage vector datapath. Tracks valid/dest info for E, M, W,
//   detects load-use and memory-wait hazards, and drives stall/flush/hold, operand forwarding
//   selects, W-to-D regfile bypass, the M-stage memory request and saturating perf counters.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : vec_pipe_hazard_ctrl_if.slave (Decode fields + mem_ready in, control out)
module vec_pipe_hazard_ctrl #(
  parameter int RA_W  = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  vec_pipe_hazard_ctrl_if.slave bus
);
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wa;
    logic [RA_W-1:0] ra1;
    logic [RA_W-1:0] ra2;
    logic            use1;
    logic            use2;
    logic            regWrite;
    logic            memToReg;
    logic            memWrite;
  } exStage_t;

  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wa;
    logic            regWrite;
    logic            memToReg;
    logic            memWrite;
  } memStage_t;

  // W only needs what drives the regfile write and the bypass/forward compares.
  typedef struct packed {
    logic            valid;
    logic [RA_W-1:0] wa;
    logic            regWrite;
  } wbStage_t;

  exStage_t   stE, decIn;
  memStage_t  stM;
  wbStage_t   stW;
  logic [CNT_W-1:0] stallCnt, retireCnt;
  logic memStall, luStall, stallFd;

  assign decIn = '{valid: bus.valid_d, wa: bus.wa_d, ra1: bus.ra1_d, ra2: bus.ra2_d,
                   use1: bus.use1_d, use2: bus.use2_d, regWrite: bus.regwrite_d,
                   memToReg: bus.memtoreg_d, memWrite: bus.memwrite_d};

  assign memStall = stM.valid & (stM.memToReg | stM.memWrite) & ~bus.mem_ready;
  assign luStall  = bus.valid_d & stE.valid & stE.memToReg & stE.regWrite &
                    ((bus.use1_d & (bus.ra1_d == stE.wa)) | (bus.use2_d & (bus.ra2_d == stE.wa)));
  assign stallFd  = memStall | luStall;

  always_ff @(posedge clk) begin
    if (reset) begin
      stE <= '0;
      stM <= '0;
      stW <= '0;
    end else if (memStall) begin
      // M and E freeze while memory finishes; W sees a bubble.
      stW <= '0;
    end else begin
      stW <= '{valid: stM.valid, wa: stM.wa, regWrite: stM.regWrite};
      stM <= '{valid: stE.valid, wa: stE.wa, regWrite: stE.regWrite,
               memToReg: stE.memToReg, memWrite: stE.memWrite};
      stE <= luStall ? '0 : decIn;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt  <= '0;
      retireCnt <= '0;
    end else begin
      if (stallFd && stallCnt != '1)      stallCnt  <= stallCnt + 1'b1;
      if (stW.valid && retireCnt != '1)   retireCnt <= retireCnt + 1'b1;
    end
  end

  // M ALU result beats the older W result; a load in M never forwards (its data isn't back yet).
  function automatic logic [1:0] fwdSel(input logic srcUsed, input logic [RA_W-1:0] ra);
    if (stM.valid && stM.regWrite && !stM.memToReg && srcUsed && stM.wa == ra) return 2'b10;
    if (stW.valid && stW.regWrite && srcUsed && stW.wa == ra)                   return 2'b01;
    return 2'b00;
  endfunction

  assign bus.fwd_a_e    = fwdSel(stE.use1, stE.ra1);
  assign bus.fwd_b_e    = fwdSel(stE.use2, stE.ra2);
  assign bus.wbyp1_d    = stW.valid & stW.regWrite & bus.use1_d & (stW.wa == bus.ra1_d);
  assign bus.wbyp2_d    = stW.valid & stW.regWrite & bus.use2_d & (stW.wa == bus.ra2_d);
  assign bus.stall_fd   = stallFd;
  assign bus.hold_em    = memStall;
  assign bus.flush_e    = luStall & ~memStall;
  assign bus.mem_req_m  = stM.valid & (stM.memToReg | stM.memWrite);
  assign bus.mem_we_m   = stM.valid & stM.memWrite;
  assign bus.regwrite_w = stW.valid & stW.regWrite;
  assign bus.wa_w       = stW.wa;
  assign bus.stall_cnt  = stallCnt;
  assign bus.retire_cnt = retireCnt;

  // The load-use stall must keep a load in M from ever feeding a dependent in E.
  loadInMFeedsE: assert property (@(posedge clk) disable iff (reset)
    !(stM.valid && stM.memToReg && stM.regWrite && stE.valid &&
      ((stE.use1 && stM.wa == stE.ra1) || (stE.use2 && stM.wa == stE.ra2))));
endmodule

// File: tb/tb_vec_pipe_hazard_ctrl.sv
module tb_vec_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset2 = 1'b1;
  always #5 clk = ~clk;

  vec_pipe_hazard_ctrl_if #(.RA_W(4), .CNT_W(16)) bus ();
  vec_pipe_hazard_ctrl_if #(.RA_W(4), .CNT_W(2))  bus2 ();

  vec_pipe_hazard_ctrl #(.RA_W(4), .CNT_W(16)) dut  (.clk(clk), .reset(reset),  .bus(bus));
  vec_pipe_hazard_ctrl #(.RA_W(4), .CNT_W(2))  dut2 (.clk(clk), .reset(reset2), .bus(bus2));

  typedef struct packed {
    logic vd; logic [3:0] ra1, ra2; logic u1, u2; logic [3:0] wa; logic rw, mtr, mw;
  } dIn_t;

  typedef struct packed {
    logic stall, flush, hold; logic [1:0] fa, fb; logic wb1, wb2, req, we, rww;
    logic [3:0] waw; logic [15:0] scnt, rcnt;
  } eOut_t;

  typedef struct { logic chk, rst, rdy; dIn_t d; eOut_t e; } vec_t;

  vec_t tbl[$];
  int checks = 0, errors = 0;
  eOut_t act;

  assign act = {bus.stall_fd, bus.flush_e, bus.hold_em, bus.fwd_a_e, bus.fwd_b_e, bus.wbyp1_d,
                bus.wbyp2_d, bus.mem_req_m, bus.mem_we_m, bus.regwrite_w, bus.wa_w,
                bus.stall_cnt, bus.retire_cnt};

  function automatic dIn_t idle();
    return '0;
  endfunction
  function automatic dIn_t alu(input int a, input int b, input int w);
    dIn_t d = '0;
    d.vd = 1; d.ra1 = 4'(a); d.ra2 = 4'(b); d.u1 = 1; d.u2 = 1; d.wa = 4'(w); d.rw = 1;
    return d;
  endfunction
  function automatic dIn_t ld(input int a, input int w);
    dIn_t d = '0;
    d.vd = 1; d.ra1 = 4'(a); d.u1 = 1; d.wa = 4'(w); d.rw = 1; d.mtr = 1;
    return d;
  endfunction
  function automatic dIn_t st(input int a, input int b);
    dIn_t d = '0;
    d.vd = 1; d.ra1 = 4'(a); d.ra2 = 4'(b); d.u1 = 1; d.u2 = 1; d.mw = 1;
    return d;
  endfunction
  // Invalid Decode slot that still presents a register read (for the W bypass).
  function automatic dIn_t probe(input int a);
    dIn_t d = '0;
    d.ra1 = 4'(a); d.u1 = 1;
    return d;
  endfunction

  // stall flush hold fa fb wb1 wb2 req we rww waw scnt rcnt
  function automatic eOut_t ev(input logic s, f, h, input logic [1:0] fa, fb,
                               input logic b1, b2, rq, we, rw, input int waw, sc, rc);
    eOut_t e;
    e.stall = s; e.flush = f; e.hold = h; e.fa = fa; e.fb = fb; e.wb1 = b1; e.wb2 = b2;
    e.req = rq; e.we = we; e.rww = rw; e.waw = 4'(waw); e.scnt = 16'(sc); e.rcnt = 16'(rc);
    return e;
  endfunction
  function automatic eOut_t z(input int sc, input int rc);
    return ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, sc, rc);
  endfunction
  function automatic eOut_t memWait(input int sc, input int rc);
    return ev(1, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, sc, rc);
  endfunction
  function automatic eOut_t wb(input int waw, input int sc, input int rc);
    return ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 1, waw, sc, rc);
  endfunction

  task automatic add(input logic rst, input logic rdy, input dIn_t d, input eOut_t e,
                     input logic chk = 1'b1);
    vec_t v;
    v.chk = chk; v.rst = rst; v.rdy = rdy; v.d = d; v.e = e;
    tbl.push_back(v);
  endtask

  task automatic drive(input dIn_t d, input logic rdy);
    bus.valid_d = d.vd; bus.ra1_d = d.ra1; bus.ra2_d = d.ra2; bus.use1_d = d.u1;
    bus.use2_d = d.u2; bus.wa_d = d.wa; bus.regwrite_d = d.rw; bus.memtoreg_d = d.mtr;
    bus.memwrite_d = d.mw; bus.mem_ready = rdy;
  endtask

  task automatic drive2(input dIn_t d, input logic rdy);
    bus2.valid_d = d.vd; bus2.ra1_d = d.ra1; bus2.ra2_d = d.ra2; bus2.use1_d = d.u1;
    bus2.use2_d = d.u2; bus2.wa_d = d.wa; bus2.regwrite_d = d.rw; bus2.memtoreg_d = d.mtr;
    bus2.memwrite_d = d.mw; bus2.mem_ready = rdy;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    drive(idle(), 1'b0);
    drive2(idle(), 1'b0);

    // Reset and back-to-back forwarding: M wins over an older W writer of the same reg.
    add(1, 0, idle(), z(0, 0), 1'b0);
    add(0, 0, idle(), z(0, 0));                                            // reset state
    add(0, 0, alu(1, 2, 3), z(0, 0));
    add(0, 0, alu(1, 1, 3), z(0, 0));
    add(0, 0, alu(3, 1, 4), z(0, 0));
    add(0, 0, idle(), ev(0, 0, 0, 2'b10, 2'b00, 0, 0, 0, 0, 1, 3, 0, 0));
    // add r3; nop; sub r5,r1,r3 twice: W forward in E, then W->D bypass.
    add(0, 0, alu(1, 2, 3), wb(3, 0, 1));
    add(0, 0, idle(), wb(4, 0, 2));
    add(0, 0, alu(1, 3, 5), z(0, 3));
    add(0, 0, alu(1, 3, 5), ev(0, 0, 0, 2'b00, 2'b01, 0, 1, 0, 0, 1, 3, 0, 3));
    add(0, 0, idle(), z(0, 4));
    add(0, 0, idle(), wb(5, 0, 4));
    add(0, 0, idle(), wb(5, 0, 5));
    add(0, 0, idle(), z(0, 6));
    // Load-use with zero-wait memory.
    add(0, 1, ld(1, 5), z(0, 6));
    add(0, 1, alu(5, 2, 6), ev(1, 1, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 6));
    add(0, 1, alu(5, 2, 6), ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 1, 6));
    add(0, 0, idle(), ev(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 5, 1, 6));
    add(0, 0, idle(), z(1, 7));
    add(0, 0, idle(), wb(6, 1, 7));
    add(0, 0, idle(), z(1, 8));
    // Load waits 3 cycles in M.
    add(0, 0, ld(1, 7), z(1, 8));
    add(0, 0, idle(), z(1, 8));
    add(0, 0, idle(), memWait(1, 8));
    add(0, 0, idle(), memWait(2, 8));
    add(0, 0, idle(), memWait(3, 8));
    add(0, 1, idle(), ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 4, 8));
    add(0, 0, probe(7), ev(0, 0, 0, 2'b00, 2'b00, 1, 0, 0, 0, 1, 7, 4, 8));
    add(0, 0, idle(), z(4, 9));
    // Load-use in D/E while an older load waits: memory wait wins, bubble comes after.
    add(0, 0, ld(1, 8), z(4, 9));
    add(0, 0, ld(2, 9), z(4, 9));
    add(0, 0, alu(9, 3, 10), memWait(4, 9));
    add(0, 1, alu(9, 3, 10), ev(1, 1, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 5, 9));
    add(0, 0, alu(9, 3, 10), ev(1, 0, 1, 2'b00, 2'b00, 0, 0, 1, 0, 1, 8, 6, 9));
    add(0, 1, alu(9, 3, 10), ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 0, 0, 0, 7, 10));
    add(0, 0, idle(), ev(0, 0, 0, 2'b01, 2'b00, 0, 0, 0, 0, 1, 9, 7, 10));
    add(0, 0, idle(), z(7, 11));
    add(0, 0, idle(), wb(10, 7, 11));
    add(0, 0, idle(), z(7, 12));
    // Store: write request, never writes the regfile.
    add(0, 0, st(1, 4), z(7, 12));
    add(0, 0, idle(), z(7, 12));
    add(0, 1, idle(), ev(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 1, 0, 0, 7, 12));
    add(0, 0, idle(), z(7, 12));
    // Reset in the middle of a memory wait.
    add(0, 0, ld(1, 11), z(7, 13));
    add(0, 0, idle(), z(7, 13));
    add(0, 0, idle(), memWait(7, 13));
    add(1, 0, idle(), memWait(8, 13));
    add(0, 0, idle(), z(0, 0));
    add(0, 1, idle(), z(0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst;
      drive(tbl[i].d, tbl[i].rdy);
      #1;
      if (tbl[i].chk) check($sformatf("row%0d", i), 64'(act), 64'(tbl[i].e));
    end

    // 2-bit counters: five memory-wait stalls saturate stall_cnt at 3.
    @(negedge clk); reset2 = 1'b1; drive2(idle(), 1'b0);
    @(negedge clk); reset2 = 1'b0; drive2(ld(1, 5), 1'b0);
    @(negedge clk); drive2(idle(), 1'b0);
    @(negedge clk); #1;
    check("sat_stall_on", 64'(bus2.stall_fd), 64'd1);
    check("sat_cnt0", 64'(bus2.stall_cnt), 64'd0);
    repeat (2) @(negedge clk);
    #1 check("sat_cnt2", 64'(bus2.stall_cnt), 64'd2);
    repeat (3) @(negedge clk);
    #1 check("sat_cnt3", 64'(bus2.stall_cnt), 64'd3);
    check("sat_still_stalled", 64'(bus2.stall_fd), 64'd1);
    drive2(idle(), 1'b1);
    @(negedge clk); #1;
    check("sat_hold_after", 64'(bus2.stall_cnt), 64'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
